// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, responder FSM states and size helpers
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT,
        DONE
    } state_t;

    // Number of bytes touched by an access; the reserved encoding touches none.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SIZE_BYTE ? 3'd1 :
               size == SIZE_HALF ? 3'd2 :
               size == SIZE_WORD ? 3'd4 : 3'd0;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: address/size decode into big-endian byte lanes, fault detection and load extension (DMEM_ALIGN_CHECK_EN turns misalignment into a fault)
module dmem_lane_align #(
    parameter int DEPTH = 256
) (
    input  logic [31:0]              address,
    input  logic [1:0]               size,
    input  logic                     signed_ld,
    input  logic [31:0]              wdata,
    input  logic [3:0][7:0]          rbytes,
    output logic [$clog2(DEPTH)-1:0] base,
    output logic [3:0]               be,
    output logic [3:0][7:0]          wbytes,
    output logic [31:0]              rdata,
    output logic                     fault
);
    import mem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic [31:0] ea;
    logic        misalign;
    logic [32:0] last;
    logic        ext;

    assign is_b = size == SIZE_BYTE;
    assign is_h = size == SIZE_HALF;
    assign is_w = size == SIZE_WORD;

`ifdef DMEM_ALIGN_CHECK_EN
    assign ea       = address;
    assign misalign = (is_h & address[0]) | (is_w & |address[1:0]);
`else
    assign ea       = is_h ? {address[31:1], 1'b0} : is_w ? {address[31:2], 2'b00} : address;
    assign misalign = 1'b0;
`endif

    // Last byte touched, computed one bit wider so addresses near 2^32 cannot wrap into range.
    assign last  = {1'b0, ea} + {30'b0, size_bytes(size)} - 33'd1;
    assign fault = (size == SIZE_RSVD) | misalign | (last >= 33'(DEPTH));
    assign base  = ea[AW-1:0];

    // Lane k always addresses byte base+k; the most significant store byte goes to the lowest address.
    assign be        = fault ? 4'b0000 : is_w ? 4'b1111 : is_h ? 4'b0011 : is_b ? 4'b0001 : 4'b0000;
    assign wbytes[0] = is_w ? wdata[31:24] : is_h ? wdata[15:8] : wdata[7:0];
    assign wbytes[1] = is_w ? wdata[23:16] : wdata[7:0];
    assign wbytes[2] = wdata[15:8];
    assign wbytes[3] = wdata[7:0];

    assign ext   = signed_ld & rbytes[0][7];
    assign rdata = is_w ? {rbytes[0], rbytes[1], rbytes[2], rbytes[3]} :
                   is_h ? {{16{ext}}, rbytes[0], rbytes[1]} :
                   is_b ? {{24{ext}}, rbytes[0]} : 32'd0;

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: big-endian byte-addressed data memory behind an MFA/MOC handshake with wait states (DMEM_ALIGN_CHECK_EN: misaligned accesses fault instead of being masked)
module data_memory_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mfa,
    input  logic        rw,
    input  logic [1:0]  data_size,
    input  logic        signed_ld,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        mem_err
);
    import mem_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [7:0]     mem [DEPTH];
    state_t         state;
    logic [3:0]     cnt;
    logic [31:0]    addr_q;
    logic [31:0]    data_q;
    logic [1:0]     size_q;
    logic           rw_q;
    logic           sgn_q;
    logic [AW-1:0]  base;
    logic [AW-1:0]  idx [4];
    logic [3:0]     be;
    logic [3:0][7:0] wbytes;
    logic [3:0][7:0] rbytes;
    logic [31:0]    ld_val;
    logic           fault;

    dmem_lane_align #(.DEPTH(DEPTH)) u_align (
        .address   (addr_q),
        .size      (size_q),
        .signed_ld (sgn_q),
        .wdata     (data_q),
        .rbytes    (rbytes),
        .base      (base),
        .be        (be),
        .wbytes    (wbytes),
        .rdata     (ld_val),
        .fault     (fault)
    );

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign idx[i]    = base + AW'(i);
        assign rbytes[i] = mem[idx[i]];
    end

    // Handshake FSM: latch the request, burn wait states, commit once, then hold moc until mfa drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            moc      <= 1'b0;
            mem_err  <= 1'b0;
            data_out <= 32'd0;
        end else begin
            case (state)
                IDLE: if (mfa) begin
                    addr_q <= address;
                    data_q <= data_in;
                    size_q <= data_size;
                    rw_q   <= rw;
                    sgn_q  <= signed_ld;
                    cnt    <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
                    state  <= WAIT_CYCLES > 0 ? WAIT : COMMIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= COMMIT;
                end
                COMMIT: begin
                    for (int k = 0; k < 4; k++)
                        if (be[k] && !rw_q) mem[idx[k]] <= wbytes[k];
                    mem_err <= fault;
                    if (fault) data_out <= 32'd0;
                    else if (rw_q) data_out <= ld_val;
                    state <= DONE;
                end
                DONE: begin
                    if (!moc) moc <= 1'b1;
                    else if (!mfa) begin
                        moc     <= 1'b0;
                        mem_err <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for the data memory responder
module tb_data_memory_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mfa;
    logic        rw;
    logic [1:0]  data_size;
    logic        signed_ld;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        moc;
    logic        mem_err;

    typedef struct packed {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    logic [7:0]  mdl [DEPTH];
    logic [31:0] exp_dout;
    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mfa       (mfa),
        .rw        (rw),
        .data_size (data_size),
        .signed_ld (signed_ld),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .moc       (moc),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: updates the model memory and pushes the expected response.
    task automatic model(input logic r, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] d);
        int          nb;
        logic [31:0] ea;
        logic [31:0] v;
        logic        f;
        nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : sz == 2'b10 ? 4 : 0;
`ifdef DMEM_ALIGN_CHECK_EN
        ea = a;
        f  = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
        ea = sz == 2'b01 ? a & ~32'd1 : sz == 2'b10 ? a & ~32'd3 : a;
        f  = 1'b0;
`endif
        f = f || sz == 2'b11 || (longint'(ea) + nb - 1 >= DEPTH);
        if (f) exp_dout = 32'd0;
        else if (r) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[ea + 32'(i)]);
            if (sg && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (sg && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            exp_dout = v;
        end else
            for (int i = 0; i < nb; i++) mdl[ea + 32'(i)] = d[8*(nb-1-i) +: 8];
        q.push_back('{exp_dout, f});
    endtask

    task automatic access(input logic r, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] d, input bit early_drop);
        int   n;
        exp_t e;
        @(negedge clk);
        mfa = 1'b1; rw = r; data_size = sz; signed_ld = sg; address = a; data_in = d;
        model(r, sz, sg, a, d);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (early_drop && n == 1) mfa = 1'b0;
        end while (!moc && n < 50);
        check("latency", 32'(n), 32'(W + 3));
        e = q.pop_front();
        check("data_out", data_out, e.dout);
        check("mem_err", 32'(mem_err), 32'(e.err));
        if (!early_drop) begin
            @(negedge clk);
            mfa = 1'b0;
        end
        @(posedge clk); #1;
        check("moc_fall", 32'(moc), 32'd0);
        check("err_clear", 32'(mem_err), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; mfa = 1'b0; rw = 1'b0; data_size = 2'b00; signed_ld = 1'b0;
        address = 32'd0; data_in = 32'd0; exp_dout = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", data_out, 32'd0);
        check("rst_moc", 32'(moc), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        access(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        check("plan_word", data_out, 32'hDEAD_BEEF);
        access(1'b1, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
        check("plan_sbyte", data_out, 32'hFFFF_FFBE);
        access(1'b1, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
        access(1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
        check("plan_half", data_out, 32'h0000_DEAD);
        access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0000_0055, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        check("plan_merge", data_out, 32'hDE55_BEEF);

        access(1'b0, 2'b10, 1'b0, 32'(DEPTH - 4), 32'hA1B2_C3D4, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'(DEPTH - 2), 32'h1111_2222, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'(DEPTH - 4), 32'h0, 1'b0);
        access(1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);

        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0102_0304, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        mfa = 1'b1; rw = 1'b0; data_size = 2'b10; address = 32'h20; data_in = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0; mfa = 1'b0;
        @(posedge clk); #1;
        exp_dout = 32'd0;
        check("rstwait_moc", 32'(moc), 32'd0);
        check("rstwait_dout", data_out, 32'd0);
        check("rstwait_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        access(1'b0, 2'b10, 1'b0, 32'h21, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        access(1'b1, 2'b01, 1'b1, 32'h23, 32'h0, 1'b0);

        access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0000_0077, 1'b1);
        access(1'b1, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
